// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-ported data memory between the pipeline MEM stage (port P)
// and a debug/DMA loader (port D). At most one memory command is issued per
// cycle. Grants are combinational and arrive in the same cycle as the request.
// Read data has a latency of one cycle and is routed back to whichever port
// issued the read.
//
// Arbitration:
//   - P normally wins contention. D is forced through after it has been
//     refused WAIT_MAX cycles in a row.
//   - D may take exclusive ownership with d_lock. The lock ends when D drops
//     d_lock, or after LOCK_MAX cycles. In the first cycle after a lock runs out
//     (forced exit), P has priority and D may not lock again.
//
// Ports:
//   clk, reset            clock (posedge); asynchronous active-low reset
//   p_req/p_we/p_addr/p_wdata   MEM-stage request
//   p_gnt, p_rvalid, p_rdata    MEM-stage grant and read return
//   d_req/d_we/d_addr/d_wdata/d_lock   debug/DMA request, lock request
//   d_gnt, d_rvalid, d_rdata    debug/DMA grant and read return
//   mem_en/mem_we/mem_addr/mem_wdata   memory command
//   mem_rdata             memory read data, valid one cycle after a read
//   stall_MEM             P is requesting but was not granted
//   locked                arbiter is in the locked-burst state
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int unsigned DBITS    = 32,
    parameter int unsigned WAIT_MAX = 4,
    parameter int unsigned LOCK_MAX = 8,
    parameter int unsigned CNT_BITS = 4
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             p_req,
    input  logic             p_we,
    input  logic [DBITS-1:0] p_addr,
    input  logic [DBITS-1:0] p_wdata,
    output logic             p_gnt,
    output logic             p_rvalid,
    output logic [DBITS-1:0] p_rdata,

    input  logic             d_req,
    input  logic             d_we,
    input  logic [DBITS-1:0] d_addr,
    input  logic [DBITS-1:0] d_wdata,
    input  logic             d_lock,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [DBITS-1:0] d_rdata,

    output logic             mem_en,
    output logic             mem_we,
    output logic [DBITS-1:0] mem_addr,
    output logic [DBITS-1:0] mem_wdata,
    input  logic [DBITS-1:0] mem_rdata,

    output logic             stall_MEM,
    output logic             locked
);

    typedef enum logic [0:0] {StArb, StLockD} state_e;
    typedef enum logic [1:0] {OwnNone, OwnP, OwnD} owner_e;

    localparam logic [CNT_BITS-1:0] WaitMax = CNT_BITS'(WAIT_MAX);
    localparam logic [CNT_BITS-1:0] LockMax = CNT_BITS'(LOCK_MAX);
    localparam logic [CNT_BITS-1:0] CntOne  = CNT_BITS'(1);

    state_e              state_q, state_d;
    logic [CNT_BITS-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_BITS-1:0] lock_cnt_q, lock_cnt_d;
    // Set for exactly one ARB cycle after a lock ran out: P first, no re-lock.
    logic                p_prio_q, p_prio_d;
    owner_e              rd_owner_q, rd_owner_d;

    logic lock_enter;
    logic lock_full;
    logic lock_exit;

    // -------------------------------------------------------------------------
    // Grant decision (combinational, same cycle as the request)
    // -------------------------------------------------------------------------
    always_comb begin
        p_gnt = 1'b0;
        d_gnt = 1'b0;
        if (reset) begin
            unique case (state_q)
                StLockD: begin
                    d_gnt = d_req;
                end
                default: begin
                    if (p_req && d_req) begin
                        if ((wait_cnt_q == WaitMax) && !p_prio_q) begin
                            d_gnt = 1'b1;
                        end else begin
                            p_gnt = 1'b1;
                        end
                    end else begin
                        p_gnt = p_req;
                        d_gnt = d_req;
                    end
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Memory command mux; idle fields are driven to zero
    // -------------------------------------------------------------------------
    always_comb begin
        mem_en    = p_gnt | d_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (p_gnt) begin
            mem_we    = p_we;
            mem_addr  = p_addr;
            mem_wdata = p_wdata;
        end
    end

    assign stall_MEM = reset & p_req & ~p_gnt;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    assign lock_enter = (state_q == StArb) && d_gnt && d_lock && !p_prio_q;
    assign lock_full  = (lock_cnt_q == LockMax);
    assign lock_exit  = (state_q == StLockD) && (!d_lock || lock_full);

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        p_prio_d   = 1'b0;

        unique case (state_q)
            StLockD: begin
                if (lock_exit) begin
                    state_d    = StArb;
                    lock_cnt_d = '0;
                    p_prio_d   = lock_full;
                end else begin
                    // Counts cycles in the burst, granted or not.
                    lock_cnt_d = lock_cnt_q + CntOne;
                end
            end
            default: begin
                if (lock_enter) begin
                    state_d    = StLockD;
                    lock_cnt_d = CntOne;
                end
            end
        endcase
    end

    always_comb begin
        if (lock_enter || !d_req || d_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WaitMax) begin
            wait_cnt_d = wait_cnt_q + CntOne;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    always_comb begin
        rd_owner_d = OwnNone;
        if (p_gnt && !p_we) begin
            rd_owner_d = OwnP;
        end else if (d_gnt && !d_we) begin
            rd_owner_d = OwnD;
        end
    end

    // -------------------------------------------------------------------------
    // State registers; an in-flight read is discarded by reset
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StArb;
            wait_cnt_q <= '0;
            lock_cnt_q <= '0;
            p_prio_q   <= 1'b0;
            rd_owner_q <= OwnNone;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            lock_cnt_q <= lock_cnt_d;
            p_prio_q   <= p_prio_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // -------------------------------------------------------------------------
    // Registered status and read return
    // -------------------------------------------------------------------------
    assign locked   = (state_q == StLockD);
    assign p_rvalid = (rd_owner_q == OwnP);
    assign d_rvalid = (rd_owner_q == OwnD);
    assign p_rdata  = p_rvalid ? mem_rdata : '0;
    assign d_rdata  = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int unsigned WAIT_MAX = 4;
    localparam int unsigned LOCK_MAX = 8;

    logic        clk;
    logic        reset;
    logic        p_req, p_we;
    logic [31:0] p_addr, p_wdata;
    logic        p_gnt, p_rvalid;
    logic [31:0] p_rdata;
    logic        d_req, d_we, d_lock;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall_MEM, locked;

    dmem_arbiter #(
        .DBITS   (32),
        .WAIT_MAX(WAIT_MAX),
        .LOCK_MAX(LOCK_MAX),
        .CNT_BITS(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .p_req    (p_req),
        .p_we     (p_we),
        .p_addr   (p_addr),
        .p_wdata  (p_wdata),
        .p_gnt    (p_gnt),
        .p_rvalid (p_rvalid),
        .p_rdata  (p_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_lock   (d_lock),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .stall_MEM(stall_MEM),
        .locked   (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory environment: write at the grant edge, read data one cycle later.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
            else        mem_rdata <= mem[mem_addr[9:2]];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    endtask

    // ---------------------------------------------------------------------
    // Reference model: rules of the arbiter in plain integers and a shadow
    // copy of memory contents.
    // ---------------------------------------------------------------------
    bit          m_lock;       // exclusive burst in progress
    int unsigned m_cnt;        // cycles spent in the current burst (1-based)
    int unsigned m_wait;       // consecutive refused D cycles
    bit          m_pfirst;     // first cycle after a burst ran out
    int          m_owner;      // 0 none, 1 P, 2 D: who gets read data now
    logic [31:0] m_rd;         // expected read data for m_owner
    logic [31:0] shadow [256];
    bit          eg_p, eg_d;   // expected grants of the last modelled cycle

    function automatic int widx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    task automatic model_step();
        bit fp, fd, enter, forced, leave;
        logic        ewe;
        logic [31:0] ea, ew;
        if (!reset) begin
            chk1("rst_p_gnt", p_gnt, 1'b0);
            chk1("rst_d_gnt", d_gnt, 1'b0);
            chk1("rst_mem_en", mem_en, 1'b0);
            chk1("rst_mem_we", mem_we, 1'b0);
            chk1("rst_stall", stall_MEM, 1'b0);
            chk1("rst_locked", locked, 1'b0);
            chk1("rst_p_rvalid", p_rvalid, 1'b0);
            chk1("rst_d_rvalid", d_rvalid, 1'b0);
            chk32("rst_p_rdata", p_rdata, 32'h0);
            chk32("rst_d_rdata", d_rdata, 32'h0);
            m_lock = 0; m_cnt = 0; m_wait = 0; m_pfirst = 0; m_owner = 0;
            eg_p = 0; eg_d = 0;
            return;
        end
        fp = 0; fd = 0;
        if (m_lock) fd = d_req;
        else if (p_req && d_req) begin
            if (m_wait == WAIT_MAX && !m_pfirst) fd = 1;
            else fp = 1;
        end else begin
            fp = p_req;
            fd = d_req;
        end
        eg_p = fp; eg_d = fd;

        chk1("m_p_gnt", p_gnt, fp);
        chk1("m_d_gnt", d_gnt, fd);
        chk1("m_mem_en", mem_en, fp | fd);
        chk1("m_stall", stall_MEM, p_req & !fp);
        chk1("m_locked", locked, m_lock);
        chk1("m_p_rvalid", p_rvalid, m_owner == 1);
        chk1("m_d_rvalid", d_rvalid, m_owner == 2);
        chk32("m_p_rdata", p_rdata, (m_owner == 1) ? m_rd : 32'h0);
        chk32("m_d_rdata", d_rdata, (m_owner == 2) ? m_rd : 32'h0);
        if (fp || fd) begin
            ewe = fd ? d_we : p_we;
            ea  = fd ? d_addr : p_addr;
            ew  = fd ? d_wdata : p_wdata;
            chk1("m_mem_we", mem_we, ewe);
            chk32("m_mem_addr", mem_addr, ea);
            if (ewe) chk32("m_mem_wdata", mem_wdata, ew);
        end

        if (fp && !p_we) begin
            m_owner = 1; m_rd = shadow[widx(p_addr)];
        end else if (fd && !d_we) begin
            m_owner = 2; m_rd = shadow[widx(d_addr)];
        end else begin
            m_owner = 0;
        end
        if (fp && p_we) shadow[widx(p_addr)] = p_wdata;
        if (fd && d_we) shadow[widx(d_addr)] = d_wdata;

        enter  = !m_lock && fd && d_lock && !m_pfirst;
        forced = m_lock && (m_cnt == LOCK_MAX);
        leave  = m_lock && (!d_lock || forced);
        if (enter || !d_req || fd) m_wait = 0;
        else if (m_wait < WAIT_MAX) m_wait++;
        if (enter) begin
            m_lock = 1; m_cnt = 1;
        end else if (leave) begin
            m_lock = 0; m_cnt = 0;
        end else if (m_lock) begin
            m_cnt++;
        end
        m_pfirst = forced;
    endtask

    task automatic drive(input logic pr, input logic pw, input logic [31:0] pa,
                         input logic [31:0] pd, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] dd, input logic dl);
        p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd; d_lock = dl;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic finish_cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        finish_cycle();
    endtask

    // ---------------------------------------------------------------------
    // Directed vectors: P always reads, D never locks
    // ---------------------------------------------------------------------
    typedef struct {
        logic        pr;
        logic [31:0] pa;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dd;
        logic        e_pg, e_dg, e_st, e_pv;
        logic [31:0] e_pd;
        logic        e_dv;
        logic [31:0] e_dd;
    } vec_t;

    function automatic vec_t mkv(input logic pr, input logic [31:0] pa, input logic dr,
                                 input logic dw, input logic [31:0] da, input logic [31:0] dd,
                                 input logic epg, input logic edg, input logic est,
                                 input logic epv, input logic [31:0] epd, input logic edv,
                                 input logic [31:0] edd);
        vec_t v;
        v.pr = pr; v.pa = pa; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
        v.e_pg = epg; v.e_dg = edg; v.e_st = est; v.e_pv = epv; v.e_pd = epd;
        v.e_dv = edv; v.e_dd = edd;
        return v;
    endfunction

    vec_t tbl [15];

    logic        rpr, rpw, rdr, rdw, rdl;
    logic [31:0] rpa, rpd, rda, rdd;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 32'hA000_0000 | 32'(i);
            shadow[i] = 32'hA000_0000 | 32'(i);
        end
        mem[4]    = 32'hDEAD_BEEF;
        shadow[4] = 32'hDEAD_BEEF;

        //              pr    pa        dr    dw    da        dd
        //              pg    dg    st    pv    pd              dv    dd
        tbl[0]  = mkv(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0,
                      1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tbl[1]  = mkv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                      1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0);
        tbl[2]  = mkv(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h5A5A_5A5A,
                      1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tbl[3]  = mkv(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0,
                      1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tbl[4]  = mkv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                      1'b0, 1'b0, 1'b0, 1'b1, 32'h5A5A_5A5A, 1'b0, 32'h0);
        tbl[5]  = mkv(1'b1, 32'h10, 1'b1, 1'b0, 32'h30, 32'h0,
                      1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 6; i < 9; i++)
            tbl[i] = mkv(1'b1, 32'h10, 1'b1, 1'b0, 32'h30, 32'h0,
                         1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0);
        tbl[9]  = mkv(1'b1, 32'h10, 1'b1, 1'b0, 32'h30, 32'h0,
                      1'b0, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0);
        tbl[10] = mkv(1'b1, 32'h10, 1'b1, 1'b0, 32'h30, 32'h0,
                      1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hA000_000C);
        for (int i = 11; i < 14; i++)
            tbl[i] = mkv(1'b1, 32'h10, 1'b1, 1'b0, 32'h30, 32'h0,
                         1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0);
        tbl[14] = mkv(1'b1, 32'h10, 1'b1, 1'b0, 32'h30, 32'h0,
                      1'b0, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0);

        // Reset state
        idle();
        reset = 1'b0;
        #1;
        tick();
        tick();
        reset = 1'b1;

        // Single reads, write-then-read, and the WAIT_MAX fairness pattern
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].pr, 1'b0, tbl[i].pa, 32'h0, tbl[i].dr, tbl[i].dw,
                  tbl[i].da, tbl[i].dd, 1'b0);
            @(negedge clk);
            chk1($sformatf("v%0d_p_gnt", i), p_gnt, tbl[i].e_pg);
            chk1($sformatf("v%0d_d_gnt", i), d_gnt, tbl[i].e_dg);
            chk1($sformatf("v%0d_stall", i), stall_MEM, tbl[i].e_st);
            chk1($sformatf("v%0d_p_rvalid", i), p_rvalid, tbl[i].e_pv);
            chk32($sformatf("v%0d_p_rdata", i), p_rdata, tbl[i].e_pd);
            chk1($sformatf("v%0d_d_rvalid", i), d_rvalid, tbl[i].e_dv);
            chk32($sformatf("v%0d_d_rdata", i), d_rdata, tbl[i].e_dd);
            if (i == 0) chk32("v0_mem_addr", mem_addr, 32'h10);
            finish_cycle();
        end
        idle();
        tick();

        // Locked burst runs out after LOCK_MAX cycles, then P first
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1);
        @(negedge clk);
        chk1("lk_c0_d_gnt", d_gnt, 1'b1);
        finish_cycle();
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk1($sformatf("lk_c%0d_locked", c), locked, 1'b1);
            chk1($sformatf("lk_c%0d_p_gnt", c), p_gnt, 1'b0);
            chk1($sformatf("lk_c%0d_d_gnt", c), d_gnt, 1'b1);
            finish_cycle();
        end
        @(negedge clk);
        chk1("lk_c9_p_gnt", p_gnt, 1'b1);
        chk1("lk_c9_d_gnt", d_gnt, 1'b0);
        chk1("lk_c9_locked", locked, 1'b0);
        finish_cycle();
        for (int c = 10; c <= 13; c++) begin
            @(negedge clk);
            chk1($sformatf("lk_c%0d_p_gnt", c), p_gnt, c != 13);
            chk1($sformatf("lk_c%0d_d_gnt", c), d_gnt, c == 13);
            finish_cycle();
        end
        idle();
        tick();
        tick();

        // Lock released early by D
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk1($sformatf("er_c%0d_locked", c), locked, 1'b1);
            chk1($sformatf("er_c%0d_p_gnt", c), p_gnt, 1'b0);
            finish_cycle();
        end
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0);
        @(negedge clk);
        chk1("er_c4_locked", locked, 1'b1);
        chk1("er_c4_d_gnt", d_gnt, 1'b1);
        finish_cycle();
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk1("er_c5_locked", locked, 1'b0);
        chk1("er_c5_p_gnt", p_gnt, 1'b1);
        finish_cycle();
        idle();
        tick();

        // Reset right after a locked D read grant
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b1);
        tick();
        reset = 1'b0;
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b1);
        @(negedge clk);
        chk1("rs_d_rvalid", d_rvalid, 1'b0);
        chk1("rs_locked", locked, 1'b0);
        chk1("rs_mem_en", mem_en, 1'b0);
        chk1("rs_stall", stall_MEM, 1'b0);
        finish_cycle();
        tick();
        reset = 1'b1;
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0);
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            chk1($sformatf("rs_r%0d_p_gnt", c), p_gnt, c != 4);
            chk1($sformatf("rs_r%0d_d_gnt", c), d_gnt, c == 4);
            finish_cycle();
        end
        idle();
        tick();

        // Random traffic against the model; requesters hold until granted
        rpr = 1'b0; rpw = 1'b0; rpa = 32'h0; rpd = 32'h0;
        rdr = 1'b0; rdw = 1'b0; rda = 32'h0; rdd = 32'h0;
        for (int c = 0; c < 1000; c++) begin
            if (!rpr && $urandom_range(0, 1) == 1) begin
                rpr = 1'b1;
                rpw = 1'($urandom_range(0, 1));
                rpa = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
                rpd = $urandom;
            end
            if (!rdr && $urandom_range(0, 2) != 0) begin
                rdr = 1'b1;
                rdw = 1'($urandom_range(0, 1));
                rda = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
                rdd = $urandom;
            end
            rdl   = ($urandom_range(0, 9) < (m_lock ? 9 : 3));
            reset = ($urandom_range(0, 299) != 0);
            drive(rpr, rpw, rpa, rpd, rdr, rdw, rda, rdd, rdl);
            tick();
            if (eg_p) rpr = 1'b0;
            if (eg_d) rdr = 1'b0;
        end
        reset = 1'b1;
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
